// File: rtl/bpb_pkg.sv
// Shared types and constants for the branch predict buffer.
package bpb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // Tag is kept in a fixed 30-bit field; bits above TAG_W stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        ctr_e        ctr;
        logic [31:0] target;
    } entry_t;

    localparam ctr_e CTR_INIT     = WNT;
    localparam ctr_e CTR_ALLOC_BR = WT;
    localparam ctr_e CTR_ALLOC_J  = ST;

    function automatic logic [29:0] tag_of(input logic [31:0] addr, input int unsigned idx_w);
        return 30'(addr >> (idx_w + 32'd2));
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next state of a 2-bit saturating direction counter.
module sat_counter2 (
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'd1;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is a combinational read of the registered table; all writes land on the clock edge.
module branch_predict_buffer
    import bpb_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        d_jump,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_taddr,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        clear,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    entry_t tbl_q [ENTRIES];

    logic [IDX_W-1:0] l_idx, d_idx, u_idx;
    entry_t           l_ent, d_ent, u_ent;
    entry_t           d_new, u_new;
    logic             d_hit, u_hit;
    logic             d_write, u_write;
    logic [1:0]       u_ctr_nxt;

    assign l_idx = pc[IDX_W+1:2];
    assign d_idx = d_pc[IDX_W+1:2];
    assign u_idx = upd_pc[IDX_W+1:2];

    assign l_ent = tbl_q[l_idx];
    assign d_ent = tbl_q[d_idx];
    assign u_ent = tbl_q[u_idx];

    assign pred_hit   = l_ent.valid && (l_ent.tag == tag_of(pc, IDX_W));
    assign pred_taken = pred_hit && l_ent.ctr[1];
    assign pred_pc    = pred_taken ? l_ent.target : pc + 32'd4;

    assign d_hit = d_ent.valid && (d_ent.tag == tag_of(d_pc, IDX_W));
    assign u_hit = u_ent.valid && (u_ent.tag == tag_of(upd_pc, IDX_W));

    sat_counter2 u_sat (
        .cur   (u_ent.ctr),
        .taken (upd_taken),
        .nxt   (u_ctr_nxt)
    );

    always_comb begin
        u_new   = u_ent;
        u_write = 1'b0;
        if (upd_valid) begin
            if (u_hit) begin
                u_write   = 1'b1;
                u_new.ctr = ctr_e'(u_ctr_nxt);
                if (upd_taken) u_new.target = upd_target;
            end else if (upd_taken) begin
                u_write = 1'b1;
                u_new   = '{valid: 1'b1, tag: tag_of(upd_pc, IDX_W), ctr: CTR_ALLOC_BR,
                            target: upd_target};
            end
        end
    end

    // Execute owns the slot when both stages target the same index.
    always_comb begin
        d_new   = '{valid: 1'b1, tag: tag_of(d_pc, IDX_W), ctr: CTR_ALLOC_J, target: d_taddr};
        if (d_hit) d_new.tag = d_ent.tag;
        d_write = d_jump && !(upd_valid && (u_idx == d_idx));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_INIT, target: '0};
            end
        end else if (clear) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i].valid <= 1'b0;
                tbl_q[i].ctr   <= CTR_INIT;
            end
        end else begin
            if (d_write) tbl_q[d_idx] <= d_new;
            if (u_write) tbl_q[u_idx] <= u_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            stat_updates <= stat_updates + 32'd1;
            if (upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule
